alu_issue_ctrl: RTL
===================

// Module: alu_issue_ctrl
// PURPOSE
//  Issue/retire controller on the driving side of the ALU: accepts one 16-bit instruction,
//  reads operands from the register file, drives A/B/Opcode, captures C and the flags.
//  Writes the result back and updates the processor status register (PSR).
//  Sits between fetch and the ALU/regfile pair. Non-pipelined, one instruction in flight.
// PARAMETERS
//  REG_AW  4   register-file address width (16 GPRs)
//  DW      16  datapath width; must match ALU A/B/C
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      synchronous, active-high reset
//  instr_valid  in   1      instruction offered
//  instr        in   16     [15:12] op, [11:8] Rdest, [7:4] ext, [3:0] Rsrc; imm = [7:0]
//  instr_ready  out  1      high only in IDLE
//  rf_raddr_a   out  REG_AW read address A = Rdest
//  rf_raddr_b   out  REG_AW read address B = Rsrc
//  rf_rdata_a   in   DW     data for rf_raddr_a, valid one cycle after the address
//  rf_rdata_b   in   DW     data for rf_raddr_b, valid one cycle after the address
//  alu_a        out  DW     ALU operand A
//  alu_b        out  DW     ALU operand B
//  alu_opcode   out  8      ALU opcode, values from alu_pkg
//  alu_c        in   DW     ALU result
//  alu_carry    in   1      ALU carry flag
//  alu_flag     in   1      ALU overflow flag
//  alu_low      in   1      ALU low flag
//  alu_negative in   1      ALU negative flag
//  alu_zero     in   1      ALU zero flag
//  wb_en        out  1      one-cycle register write strobe
//  wb_addr      out  REG_AW write address = Rdest
//  wb_data      out  DW     write data
//  psr          out  5      {C,F,L,N,Z}
//  done         out  1      one-cycle pulse at retire, including illegal instructions
//  illegal      out  1      one-cycle pulse with done when decode is illegal
// BEHAVIOUR
//  Reset values: state=IDLE, psr=0, wb_en=0, done=0, illegal=0, alu_opcode=NOP(22),
//   alu_a=0, alu_b=0, wb_data=0, wb_addr=0.
//  FSM: IDLE -> READ -> EXEC -> RETIRE -> IDLE.
//   IDLE:   accept on instr_valid&&instr_ready and latch instr, then go to READ.
//           With no accept, stay in IDLE and hold alu_opcode=NOP.
//   READ:   drive rf_raddr_a/b from the latched instr; decode to alu_opcode.
//   EXEC:   drive alu_a=rf_rdata_a and alu_b=operand B; register alu_c and the flags at the edge.
//   RETIRE: pulse done; pulse wb_en if the op writes back; update PSR bits per the op.
//  Latency: accept at cycle 0, wb_en/done asserted at cycle 3. One instruction per 4 cycles.
//  Decode table:
//   op=0000, by ext: 0101 ADD, 0110 ADDU, 1001 SUB, 1011 CMP, 0001 AND, 0010 OR,
//    0011 XOR, 1111 NOT, 0000 NOP.
//   op=0101 ADDI (imm sign-extended), op=0110 ADDUI (imm zero-extended),
//    op=1001 SUBI (imm sign-extended), op=1011 CMPI (imm sign-extended).
//   op=1000, by ext: 0100 LSH, 0101 RSH, 0110 ALSH, 0111 ARSH (B=rf_rdata_b);
//    0000 LSHI, 0001 RSHI (B = zero-extended instr[3:0]).
//   All other encodings, including every ADDC-class code (ALU opcodes 4..7), are illegal:
//    no wb_en, PSR unchanged, illegal=1 with done, opcode NOP issued.
//  Write-back: every legal op except CMP, CMPI, NOP. This keeps X results off the bus.
//  PSR update, only the listed bits change:
//   ADD/ADDI/SUB/SUBI: F,Z.  ADDU/ADDUI: C,Z.  CMP: L,N,Z.  CMPI: L,Z.
//   Logic, shift, NOP: no change.
//  instr_valid while busy: ignored, not queued. The instr bus is only sampled at accept.
//  reset in any state: next cycle is IDLE with reset values; no wb_en, no done.
//   The in-flight instruction is dropped.
// STRUCTURE
//  alu_pkg: ALU opcode constants 0..22 (shared with the ALU), FSM state enum, PSR bit indices.
//  One sub-module, alu_issue_decode: combinational instr -> {opcode, imm_sel, sext,
//   wb_ok, psr_mask, illegal}. FSM and registers stay in alu_issue_ctrl.
// TESTING
//  ADD, r1=0x7FFF, r2=0x0001 -> cycle 3: wb_en, wb_data=0x8000, psr F=1, Z=0.
//  ADDUI, Rdest=0xFFFF, imm 0x01 -> wb_data=0x0000, psr C=1, Z=1, F/L/N unchanged.
//  CMP, A=0x0001, B=0xFFFF -> no wb_en, done=1, psr L=1, N=0, Z=0.
//  SUBI, A=0x0005, imm 0xFF -> B=0xFFFF, wb_data=0x0006.
//  ADDC encoding (op=0000, ext=0100) -> illegal=1, done=1, no wb_en, psr unchanged.
//  reset asserted in EXEC -> no wb_en/done; instr_ready=1 the cycle after release.
//  Back-to-back valids -> second instruction accepted at cycle 4.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg: ALU opcodes shared with the ALU, FSM states, PSR layout      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package alu_pkg;

  typedef logic [7:0] alu_op_t;

  localparam alu_op_t OP_ADD    = 8'd0;
  localparam alu_op_t OP_ADDU   = 8'd1;
  localparam alu_op_t OP_ADDI   = 8'd2;
  localparam alu_op_t OP_ADDUI  = 8'd3;
  localparam alu_op_t OP_ADDC   = 8'd4;
  localparam alu_op_t OP_ADDCU  = 8'd5;
  localparam alu_op_t OP_ADDCUI = 8'd6;
  localparam alu_op_t OP_ADDCI  = 8'd7;
  localparam alu_op_t OP_SUB    = 8'd8;
  localparam alu_op_t OP_SUBI   = 8'd9;
  localparam alu_op_t OP_CMP    = 8'd10;
  localparam alu_op_t OP_CMPI   = 8'd11;
  localparam alu_op_t OP_AND    = 8'd12;
  localparam alu_op_t OP_OR     = 8'd13;
  localparam alu_op_t OP_XOR    = 8'd14;
  localparam alu_op_t OP_NOT    = 8'd15;
  localparam alu_op_t OP_LSH    = 8'd16;
  localparam alu_op_t OP_LSHI   = 8'd17;
  localparam alu_op_t OP_RSH    = 8'd18;
  localparam alu_op_t OP_RSHI   = 8'd19;
  localparam alu_op_t OP_ALSH   = 8'd20;
  localparam alu_op_t OP_ARSH   = 8'd21;
  localparam alu_op_t OP_NOP    = 8'd22;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_READ   = 2'd1;
  localparam logic [1:0] ST_EXEC   = 2'd2;
  localparam logic [1:0] ST_RETIRE = 2'd3;

  // PSR is {C,F,L,N,Z}
  localparam int PSR_C = 4;
  localparam int PSR_F = 3;
  localparam int PSR_L = 2;
  localparam int PSR_N = 1;
  localparam int PSR_Z = 0;

  localparam logic [4:0] PSR_M_C = 5'(1) << PSR_C;
  localparam logic [4:0] PSR_M_F = 5'(1) << PSR_F;
  localparam logic [4:0] PSR_M_L = 5'(1) << PSR_L;
  localparam logic [4:0] PSR_M_N = 5'(1) << PSR_N;
  localparam logic [4:0] PSR_M_Z = 5'(1) << PSR_Z;

  typedef enum logic [1:0] {
    BSEL_REG  = 2'd0,
    BSEL_IMM8 = 2'd1,
    BSEL_IMM4 = 2'd2
  } bsel_e;

  typedef struct packed {
    alu_op_t    opcode;
    bsel_e      imm_sel;
    logic       sext;
    logic       wb_ok;
    logic [4:0] psr_mask;
    logic       illegal;
  } decode_t;

  function automatic decode_t mk_dec(alu_op_t op, bsel_e sel, logic sx, logic wb,
                                     logic [4:0] mask);
    decode_t d;
    d.opcode   = op;
    d.imm_sel  = sel;
    d.sext     = sx;
    d.wb_ok    = wb;
    d.psr_mask = mask;
    d.illegal  = 1'b0;
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_issue_ctrl_if: fetch, regfile, ALU and retire signals of the ctrl |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface alu_issue_ctrl_if #(
  parameter int REG_AW = 4,
  parameter int DW     = 16
);
  logic              instr_valid;
  logic [15:0]       instr;
  logic              instr_ready;
  logic [REG_AW-1:0] rf_raddr_a;
  logic [REG_AW-1:0] rf_raddr_b;
  logic [DW-1:0]     rf_rdata_a;
  logic [DW-1:0]     rf_rdata_b;
  logic [DW-1:0]     alu_a;
  logic [DW-1:0]     alu_b;
  logic [7:0]        alu_opcode;
  logic [DW-1:0]     alu_c;
  logic              alu_carry;
  logic              alu_flag;
  logic              alu_low;
  logic              alu_negative;
  logic              alu_zero;
  logic              wb_en;
  logic [REG_AW-1:0] wb_addr;
  logic [DW-1:0]     wb_data;
  logic [4:0]        psr;
  logic              done;
  logic              illegal;

  modport master (
    input  instr_valid, instr, rf_rdata_a, rf_rdata_b,
    input  alu_c, alu_carry, alu_flag, alu_low, alu_negative, alu_zero,
    output instr_ready, rf_raddr_a, rf_raddr_b, alu_a, alu_b, alu_opcode,
    output wb_en, wb_addr, wb_data, psr, done, illegal
  );

  modport slave (
    output instr_valid, instr, rf_rdata_a, rf_rdata_b,
    output alu_c, alu_carry, alu_flag, alu_low, alu_negative, alu_zero,
    input  instr_ready, rf_raddr_a, rf_raddr_b, alu_a, alu_b, alu_opcode,
    input  wb_en, wb_addr, wb_data, psr, done, illegal
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_issue_decode: combinational instruction decode for alu_issue_ctrl |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [3:0] op,
  input  logic [3:0] ext,
  output decode_t    dec
);

  always_comb begin
    // Anything not matched below stays illegal and issues NOP.
    dec          = '0;
    dec.opcode   = OP_NOP;
    dec.imm_sel  = BSEL_REG;
    dec.illegal  = 1'b1;
    case (op)
      4'b0000: begin
        case (ext)
          4'b0101: dec = mk_dec(OP_ADD,  BSEL_REG, 1'b0, 1'b1, PSR_M_F | PSR_M_Z);
          4'b0110: dec = mk_dec(OP_ADDU, BSEL_REG, 1'b0, 1'b1, PSR_M_C | PSR_M_Z);
          4'b1001: dec = mk_dec(OP_SUB,  BSEL_REG, 1'b0, 1'b1, PSR_M_F | PSR_M_Z);
          4'b1011: dec = mk_dec(OP_CMP,  BSEL_REG, 1'b0, 1'b0,
                                PSR_M_L | PSR_M_N | PSR_M_Z);
          4'b0001: dec = mk_dec(OP_AND,  BSEL_REG, 1'b0, 1'b1, 5'b0);
          4'b0010: dec = mk_dec(OP_OR,   BSEL_REG, 1'b0, 1'b1, 5'b0);
          4'b0011: dec = mk_dec(OP_XOR,  BSEL_REG, 1'b0, 1'b1, 5'b0);
          4'b1111: dec = mk_dec(OP_NOT,  BSEL_REG, 1'b0, 1'b1, 5'b0);
          4'b0000: dec = mk_dec(OP_NOP,  BSEL_REG, 1'b0, 1'b0, 5'b0);
          default: ;
        endcase
      end
      4'b0101: dec = mk_dec(OP_ADDI,  BSEL_IMM8, 1'b1, 1'b1, PSR_M_F | PSR_M_Z);
      4'b0110: dec = mk_dec(OP_ADDUI, BSEL_IMM8, 1'b0, 1'b1, PSR_M_C | PSR_M_Z);
      4'b1001: dec = mk_dec(OP_SUBI,  BSEL_IMM8, 1'b1, 1'b1, PSR_M_F | PSR_M_Z);
      4'b1011: dec = mk_dec(OP_CMPI,  BSEL_IMM8, 1'b1, 1'b0, PSR_M_L | PSR_M_Z);
      4'b1000: begin
        case (ext)
          4'b0100: dec = mk_dec(OP_LSH,  BSEL_REG,  1'b0, 1'b1, 5'b0);
          4'b0101: dec = mk_dec(OP_RSH,  BSEL_REG,  1'b0, 1'b1, 5'b0);
          4'b0110: dec = mk_dec(OP_ALSH, BSEL_REG,  1'b0, 1'b1, 5'b0);
          4'b0111: dec = mk_dec(OP_ARSH, BSEL_REG,  1'b0, 1'b1, 5'b0);
          4'b0000: dec = mk_dec(OP_LSHI, BSEL_IMM4, 1'b0, 1'b1, 5'b0);
          4'b0001: dec = mk_dec(OP_RSHI, BSEL_IMM4, 1'b0, 1'b1, 5'b0);
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_issue_ctrl: 4-cycle issue/retire controller driving the ALU       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int DW     = 16
) (
  input  logic            clk,
  input  logic            reset,
  alu_issue_ctrl_if.master bus
);

  logic [1:0]    state_q,   state_d;
  logic [15:0]   instr_q,   instr_d;
  alu_op_t       opcode_q,  opcode_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic [4:0]    psr_q,     psr_d;
  logic [DW-1:0] operand_b;
  logic [4:0]    alu_flags;
  decode_t       dec;

  alu_issue_decode u_decode (
    .op  (instr_q[15:12]),
    .ext (instr_q[7:4]),
    .dec (dec)
  );

  always_comb begin
    case (dec.imm_sel)
      BSEL_IMM8: operand_b = dec.sext ? {{(DW-8){instr_q[7]}}, instr_q[7:0]}
                                      : {{(DW-8){1'b0}}, instr_q[7:0]};
      BSEL_IMM4: operand_b = {{(DW-4){1'b0}}, instr_q[3:0]};
      default:   operand_b = bus.rf_rdata_b;
    endcase
  end

  assign alu_flags = {bus.alu_carry, bus.alu_flag, bus.alu_low,
                      bus.alu_negative, bus.alu_zero};

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    opcode_d  = opcode_q;
    wb_data_d = wb_data_q;
    psr_d     = psr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        opcode_d = dec.opcode;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        // Only write-back ops load the result register, so CMP/NOP never expose X data.
        if (dec.wb_ok) begin
          wb_data_d = bus.alu_c;
        end
        psr_d   = (psr_q & ~dec.psr_mask) | (alu_flags & dec.psr_mask);
        state_d = ST_RETIRE;
      end
      default: begin
        opcode_d = OP_NOP;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      opcode_q  <= OP_NOP;
      wb_data_q <= '0;
      psr_q     <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      opcode_q  <= opcode_d;
      wb_data_q <= wb_data_d;
      psr_q     <= psr_d;
    end
  end

  assign bus.instr_ready = (state_q == ST_IDLE);
  assign bus.rf_raddr_a  = instr_q[8 +: REG_AW];
  assign bus.rf_raddr_b  = instr_q[0 +: REG_AW];
  assign bus.alu_a       = (state_q == ST_EXEC) ? bus.rf_rdata_a : '0;
  assign bus.alu_b       = (state_q == ST_EXEC) ? operand_b : '0;
  assign bus.alu_opcode  = opcode_q;
  assign bus.wb_en       = (state_q == ST_RETIRE) && dec.wb_ok;
  assign bus.wb_addr     = instr_q[8 +: REG_AW];
  assign bus.wb_data     = wb_data_q;
  assign bus.psr         = psr_q;
  assign bus.done        = (state_q == ST_RETIRE);
  assign bus.illegal     = (state_q == ST_RETIRE) && dec.illegal;

endmodule
`default_nettype wire
